axis_boxcar_decimator: RTL and testbench

- Downstream consumer of the splitter's M_AXIS stream.
- Accumulates 2^k consecutive valid samples (boxcar) and emits their arithmetic mean as one output beat, reducing the sample rate by 2^k.
- Feeds the slow monitor/recorder path of the RPSPMC signal chain.
- Valid-only AXIS on both sides: no tready; the block never stalls.

---
 rtl/axis_boxcar_decimator.sv | 116 +++++++++++
 tb/tb_axis_boxcar_decimator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// axis_boxcar_decimator
//
// Purpose:
//   Boxcar decimator for a valid-only AXI-Stream sample stream. The block
//   sums 2^k consecutive valid signed samples and emits their floor mean as
//   one output beat. This reduces the sample rate by 2^k. There is no tready
//   on either side, so the block never stalls.
//
// Ports:
//   a_clk          sole clock, rising edge
//   a_rst          synchronous active-high reset
//   S_AXIS_tdata   signed input sample (SAXIS_TDATA_WIDTH)
//   S_AXIS_tvalid  input sample qualifier
//   log2_dec       requested exponent k, clamped to LOG2_MAX, latched per block
//   restart        discards the partial block; a same-edge sample starts anew
//   M_AXIS_tdata   mean of the last completed block, sign-extended
//   M_AXIS_tvalid  one-cycle pulse per completed block
//   block_count    completed blocks, wraps modulo 2^32
//   monitor        copy of M_AXIS_tdata
// ---------------------------------------------------------------------------
module axis_boxcar_decimator #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int LOG2_MAX          = 8,
  parameter int ACC_WIDTH         = SAXIS_TDATA_WIDTH + LOG2_MAX
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  input  logic [3:0]                   log2_dec,
  input  logic                         restart,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  output logic [31:0]                  block_count,
  output logic [MAXIS_TDATA_WIDTH-1:0] monitor
);

  // The counter must be able to represent 2^LOG2_MAX for the end-of-block compare.
  localparam int         CW   = LOG2_MAX + 1;
  localparam logic [3:0] KMAX = 4'(LOG2_MAX);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                         r_state;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic [CW-1:0]                  r_count;
  logic [3:0]                     r_k_lat;
  logic [MAXIS_TDATA_WIDTH-1:0]   r_tdata;
  logic                           r_tvalid;
  logic [31:0]                    r_block_count;

  logic                           w_start;
  logic [3:0]                     w_k_new;
  logic [3:0]                     w_k_eff;
  logic signed [ACC_WIDTH-1:0]    w_sample_ext;
  logic signed [ACC_WIDTH-1:0]    w_acc_base;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic [CW-1:0]                  w_cnt_inc;
  logic                           w_last;
  logic signed [SAXIS_TDATA_WIDTH-1:0] w_mean;

  // A new block begins on restart, or when no partial block is open.
  assign w_start      = restart || (r_count == '0) || (r_state == IDLE);
  assign w_k_new      = (log2_dec > KMAX) ? KMAX : log2_dec;
  // At a block start the fresh exponent applies to this very sample.
  assign w_k_eff      = w_start ? w_k_new : r_k_lat;
  assign w_sample_ext = ACC_WIDTH'($signed(S_AXIS_tdata));
  assign w_acc_base   = w_start ? '0 : r_acc;
  assign w_sum        = w_acc_base + w_sample_ext;
  assign w_cnt_inc    = w_start ? CW'(1) : r_count + CW'(1);
  // Block closes when this sample brings the count to 2^k (k=0: every sample).
  assign w_last       = (w_cnt_inc == (CW'(1) << w_k_eff));
  // Arithmetic shift gives floor division; the mean always fits the input width.
  assign w_mean       = SAXIS_TDATA_WIDTH'(w_sum >>> w_k_eff);

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_k_lat       <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_block_count <= '0;
    end else begin
      r_tvalid <= 1'b0;
      if (S_AXIS_tvalid) begin
        r_state <= ACC;
        if (w_start) begin
          r_k_lat <= w_k_new;
        end
        if (w_last) begin
          r_tdata       <= MAXIS_TDATA_WIDTH'(w_mean);
          r_tvalid      <= 1'b1;
          r_block_count <= r_block_count + 32'd1;
          r_count       <= '0;
          r_acc         <= '0;
        end else begin
          r_acc   <= w_sum;
          r_count <= w_cnt_inc;
        end
      end else if (restart) begin
        r_count <= '0;
        r_acc   <= '0;
      end
    end
  end

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;
  assign block_count   = r_block_count;
  assign monitor       = r_tdata;

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// tb_axis_boxcar_decimator
//
// Directed bench for axis_boxcar_decimator with default parameters (32-bit
// in/out, LOG2_MAX=8). Inputs are driven 1 ns after a rising edge. Outputs
// are checked 1 ns after the following edge. All expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axis_boxcar_decimator;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [31:0] S_AXIS_tdata = '0;
  logic        S_AXIS_tvalid = 1'b0;
  logic [3:0]  log2_dec = '0;
  logic        restart = 1'b0;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic [31:0] block_count;
  logic [31:0] monitor;

  int total = 0;
  int bad   = 0;

  axis_boxcar_decimator dut (
    .a_clk         (a_clk),
    .a_rst         (a_rst),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .log2_dec      (log2_dec),
    .restart       (restart),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .block_count   (block_count),
    .monitor       (monitor)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, pass the edge, settle 1 ns.
  task automatic step(input logic v, input logic [31:0] d, input logic rs);
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = d;
    restart       = rs;
    @(posedge a_clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] exp_d, input logic [31:0] exp_bc);
    chk({tag, ".tvalid"}, {31'd0, M_AXIS_tvalid}, 32'd1);
    chk({tag, ".tdata"},  M_AXIS_tdata, exp_d);
    chk({tag, ".monitor"}, monitor, exp_d);
    chk({tag, ".count"},  block_count, exp_bc);
    $display("beat %s tdata=%h block_count=%0d", tag, M_AXIS_tdata, block_count);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".tvalid"}, {31'd0, M_AXIS_tvalid}, 32'd0);
  endtask

  initial begin
    // Reset
    a_rst = 1'b1;
    step(1'b1, 32'd77, 1'b0);
    step(1'b1, 32'd77, 1'b0);
    chk("rst.tdata",   M_AXIS_tdata, 32'd0);
    chk("rst.tvalid",  {31'd0, M_AXIS_tvalid}, 32'd0);
    chk("rst.count",   block_count, 32'd0);
    chk("rst.monitor", monitor, 32'd0);
    a_rst = 1'b0;
    step(1'b0, 32'd0, 1'b0);

    // Normal block: k=2, 1..4 -> 10>>>2 = 2
    log2_dec = 4'd2;
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd2, 1'b0);
    step(1'b1, 32'd3, 1'b0);
    chk_quiet("norm.pre");
    step(1'b1, 32'd4, 1'b0);
    chk_beat("norm", 32'd2, 32'd1);
    step(1'b0, 32'd0, 1'b0);
    chk_quiet("norm.post");
    chk("norm.hold", M_AXIS_tdata, 32'd2);

    // Negative floor: k=1, -1,-2 -> -3>>>1 = -2 ; -4,-4 -> -4
    log2_dec = 4'd1;
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 32'hFFFF_FFFE, 1'b0);
    chk_beat("neg1", 32'hFFFF_FFFE, 32'd2);
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    chk_quiet("neg2.pre");
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    chk_beat("neg2", 32'hFFFF_FFFC, 32'd3);

    // Pass-through k=0: back-to-back 5, -7, 9
    log2_dec = 4'd0;
    step(1'b1, 32'd5, 1'b0);
    chk_beat("pt5", 32'd5, 32'd4);
    step(1'b1, 32'hFFFF_FFF9, 1'b0);
    chk_beat("ptm7", 32'hFFFF_FFF9, 32'd5);
    step(1'b1, 32'd9, 1'b0);
    chk_beat("pt9", 32'd9, 32'd6);
    step(1'b0, 32'd0, 1'b0);
    chk_quiet("pt.post");

    // k=3 with valid every other cycle: 1..8 -> 36>>>3 = 4
    log2_dec = 4'd3;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 7) chk_quiet("gap.pre");
      if (i == 8) chk_beat("gap", 32'd4, 32'd7);
      step(1'b0, 32'hDEAD_BEEF, 1'b0);
      if (i == 8) chk_quiet("gap.post");
    end

    // log2_dec 2->3 mid-block: closes after 4 (mean 10), next block takes 8
    log2_dec = 4'd2;
    step(1'b1, 32'd10, 1'b0);
    step(1'b1, 32'd10, 1'b0);
    log2_dec = 4'd3;
    step(1'b1, 32'd10, 1'b0);
    step(1'b1, 32'd10, 1'b0);
    chk_beat("kchg", 32'd10, 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 3) chk_quiet("knext.mid");
    end
    chk_beat("knext", 32'd3, 32'd9);

    // restart: partial block of 3 discarded; restart+6 also beats a same-edge completion
    log2_dec = 4'd2;
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk_quiet("rs.only");
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd6, 1'b1);
    chk_quiet("rs.valid");
    chk("rs.count", block_count, 32'd9);
    step(1'b1, 32'd6, 1'b0);
    step(1'b1, 32'd6, 1'b0);
    chk_quiet("rs.pre");
    step(1'b1, 32'd6, 1'b0);
    chk_beat("rs", 32'd6, 32'd10);

    // Extremes: log2_dec=15 clamps to 8
    log2_dec = 4'd15;
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 32'h7FFF_FFFF, 1'b0);
      if (i == 255) chk_quiet("maxpos.pre");
    end
    chk_beat("maxpos", 32'h7FFF_FFFF, 32'd11);
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 32'h8000_0000, 1'b0);
      if (i == 255) chk_quiet("maxneg.pre");
    end
    chk_beat("maxneg", 32'h8000_0000, 32'd12);

    // Reset mid-block: partial sum 3+3 must be lost
    log2_dec = 4'd2;
    step(1'b1, 32'd3, 1'b0);
    step(1'b1, 32'd3, 1'b0);
    a_rst = 1'b1;
    step(1'b1, 32'd3, 1'b0);
    chk("mrst.tdata",   M_AXIS_tdata, 32'd0);
    chk("mrst.tvalid",  {31'd0, M_AXIS_tvalid}, 32'd0);
    chk("mrst.count",   block_count, 32'd0);
    chk("mrst.monitor", monitor, 32'd0);
    a_rst = 1'b0;
    step(1'b1, 32'd8, 1'b0);
    step(1'b1, 32'd8, 1'b0);
    step(1'b1, 32'd8, 1'b0);
    chk_quiet("mrst.pre");
    step(1'b1, 32'd8, 1'b0);
    chk_beat("mrst", 32'd8, 32'd1);
    step(1'b0, 32'd0, 1'b0);
    chk_quiet("mrst.post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
